// File: rtl/atd_block_router.sv
// atd_block_router: takes 128-bit blocks from the ATD serial-to-parallel stage.
// The first block after reset or after a rekey request becomes the key. Every
// other block goes into a small show-ahead FIFO that feeds the cipher core.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ARMED    | capture allowed when data_ready=1 and the target has room
// TAKEN    | data_taken=1 for this single cycle
// WAIT_LOW | block consumed; wait for data_ready=0 before re-arming
module atd_block_router #(
  parameter int BLOCK_W    = 128,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_ready,
  input  logic [BLOCK_W-1:0] ATD_parallel,
  output logic               data_taken,
  input  logic               rekey,
  output logic [BLOCK_W-1:0] key_out,
  output logic               key_valid,
  output logic [BLOCK_W-1:0] blk_out,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [CNT_W-1:0]   blk_cnt,
  output logic               busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    TAKEN    = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic               rekey_pend_q, rekey_pend_d;
  logic               key_valid_q, key_valid_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] mem_q [FIFO_DEPTH];
  logic [BLOCK_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     fcnt_q, fcnt_d;
  logic [BLOCK_W-1:0] blk_out_q, blk_out_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

  logic fifo_empty;
  logic room;
  logic capture;
  logic key_load;
  logic push;
  logic pop;

  // Capture qualification. Key loads wait for an empty FIFO so queued data
  // still drains under the old key; FIFO room uses the pre-pop count.
  always_comb begin
    fifo_empty = (fcnt_q == '0);
    room       = rekey_pend_q ? fifo_empty : (fcnt_q < DEPTH_C);
    capture    = (state_q == ARMED) && data_ready && room;
    key_load   = capture && rekey_pend_q;
    push       = capture && !rekey_pend_q;
    pop        = !fifo_empty && blk_ready;
  end

  // Handshake FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED:    if (capture) state_d = TAKEN;
      TAKEN:    state_d = WAIT_LOW;
      WAIT_LOW: if (!data_ready) state_d = ARMED;
      default:  state_d = ARMED;
    endcase
  end

  // Key register and pending-rekey flag; a rekey that arrives while a key
  // load is already pending has nothing left to do.
  always_comb begin
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    rekey_pend_d = rekey_pend_q;
    if (key_load) begin
      key_d        = ATD_parallel;
      key_valid_d  = 1'b1;
      rekey_pend_d = 1'b0;
    end else if (rekey) begin
      rekey_pend_d = 1'b1;
    end
  end

  // FIFO storage, pointers, occupancy and pop counter. The head register
  // follows the post-edge head entry and keeps its last value when empty.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fcnt_d    = fcnt_q;
    blk_cnt_d = blk_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = ATD_parallel;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      blk_cnt_d = blk_cnt_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    blk_out_d = (fcnt_d != '0) ? mem_d[rd_ptr_d] : blk_out_q;
  end

  // State registers; reset discards queued blocks and re-arms for a key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARMED;
      rekey_pend_q <= 1'b1;
      key_valid_q  <= 1'b0;
      key_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
      blk_out_q    <= '0;
      blk_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rekey_pend_q <= rekey_pend_d;
      key_valid_q  <= key_valid_d;
      key_q        <= key_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcnt_q       <= fcnt_d;
      blk_out_q    <= blk_out_d;
      blk_cnt_q    <= blk_cnt_d;
    end
  end

  assign data_taken = (state_q == TAKEN);
  assign key_out    = key_q;
  assign key_valid  = key_valid_q;
  assign blk_out    = blk_out_q;
  assign blk_valid  = !fifo_empty;
  assign blk_cnt    = blk_cnt_q;
  assign busy       = rekey_pend_q || !fifo_empty;

endmodule
